// File: rtl/regbank_access_ctrl.sv
// -----------------------------------------------------------------------------
// regbank_access_ctrl
//
// Sequences and arbitrates access from two requesters to a bank of NREGS
// level-sensitive "set" latch words (data in, set strobe, data out).
//
// Writes run as setup / strobe / hold so a latch never sees its data bus move
// while its set strobe is high. Reads sample the selected latch output and
// return it in a flop. Every output is driven straight from a flop, so
// cell_set (a registered one-hot decode) cannot glitch.
//
// Handshake (both ports): a requester raises reqN with weN/addrN/wdataN stable
// and keeps them stable until it samples ackN, a single-cycle pulse. It drops
// or re-drives reqN on that same edge. A reqN still high in the IDLE cycle
// after ACK is a new request. Request changes after grant are ignored until
// the controller is back in IDLE.
//
// Ports:
//   clk, rst_n              system clock (rising edge), async active-low reset
//   req/we/addr/wdata 0,1   requester inputs
//   ack0, ack1              one-cycle completion pulses
//   rdata0, rdata1          read data, valid with ack, held until next read ack
//   cell_in                 shared data bus to all storage latches
//   cell_set                per-latch set strobes, at most one bit high
//   cell_out                concatenated latch outputs, reg k at [k*WIDTH +: WIDTH]
//   busy                    high whenever the FSM is not in IDLE
//   dbg_state               current FSM state encoding (observation only)
// -----------------------------------------------------------------------------
module regbank_access_ctrl #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0,
  input  logic                   we0,
  input  logic [ADDR_W-1:0]      addr0,
  input  logic [WIDTH-1:0]       wdata0,
  output logic                   ack0,
  output logic [WIDTH-1:0]       rdata0,
  input  logic                   req1,
  input  logic                   we1,
  input  logic [ADDR_W-1:0]      addr1,
  input  logic [WIDTH-1:0]       wdata1,
  output logic                   ack1,
  output logic [WIDTH-1:0]       rdata1,
  output logic [WIDTH-1:0]       cell_in,
  output logic [NREGS-1:0]       cell_set,
  input  logic [NREGS*WIDTH-1:0] cell_out,
  output logic                   busy,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_SETUP   = 3'd1,
    W_STROBE  = 3'd2,
    W_HOLD    = 3'd3,
    R_CAPTURE = 3'd4,
    ACK       = 3'd5
  } state_t;

  state_t            state, state_nxt;

  // Arbitration result for the current IDLE cycle
  logic              grant_any;
  logic              win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [WIDTH-1:0]  win_wdata;

  // Operation context captured at grant
  logic [ADDR_W-1:0] addr_q;
  logic              port_q;
  logic              last_grant;

  // Address decode / read mux driven from the captured address
  logic [NREGS-1:0]  set_dec;
  logic [WIDTH-1:0]  rd_mux;

  // Round robin: on a tie the port that did not win last time gets the grant.
  // With a single requester, that requester wins.
  always_comb begin
    grant_any = req0 | req1;
    if (req0 && req1) begin
      win = ~last_grant;
    end else begin
      win = req1;
    end
    win_we    = win ? we1    : we0;
    win_addr  = win ? addr1  : addr0;
    win_wdata = win ? wdata1 : wdata0;
  end

  // Out-of-range addresses match no k, so they decode to no strobe and read 0.
  always_comb begin
    set_dec = '0;
    rd_mux  = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (addr_q == ADDR_W'(k)) begin
        set_dec[k] = 1'b1;
        rd_mux     = cell_out[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant_any) state_nxt = win_we ? W_SETUP : R_CAPTURE;
      W_SETUP:   state_nxt = W_STROBE;
      W_STROBE:  state_nxt = W_HOLD;
      W_HOLD:    state_nxt = ACK;
      R_CAPTURE: state_nxt = ACK;
      ACK:       state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      port_q     <= 1'b0;
      last_grant <= 1'b1;
      cell_in    <= '0;
      cell_set   <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      busy       <= 1'b0;
    end else begin
      if (state == IDLE && grant_any) begin
        addr_q     <= win_addr;
        port_q     <= win;
        last_grant <= win;
        // cell_in is the captured write data; it settles during W_SETUP,
        // a full cycle ahead of the strobe, and is not touched by reads.
        if (win_we) begin
          cell_in <= win_wdata;
        end
      end

      // Strobe is high only for the W_STROBE cycle.
      cell_set <= (state == W_SETUP) ? set_dec : '0;

      if (state == R_CAPTURE) begin
        if (port_q) begin
          rdata1 <= rd_mux;
        end else begin
          rdata0 <= rd_mux;
        end
      end

      ack0 <= (state_nxt == ACK) && !port_q;
      ack1 <= (state_nxt == ACK) &&  port_q;
      busy <= (state_nxt != IDLE);
    end
  end

  assign dbg_state = state;

endmodule
